// File: rtl/pipe_stall_ctrl_if.sv
// Stall-control bundle between the hazard/memory side and the pipeline stage registers.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall_pipeline;
    logic             flush_EX;
    logic             mem_wait;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             exmem_we;
    logic             memwb_we;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output stall_pipeline, flush_EX, mem_wait,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, memwb_we, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  stall_pipeline, flush_EX, mem_wait,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, memwb_we, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// 5-stage pipeline stall/flush controller: zero-latency stage enables, pended flush
// across memory waits, memory-wait timeout and saturating performance counters.
module pipe_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] MWAIT = 1'b1;

    logic [0:0]       state;
    logic             pend_flush;
    logic [15:0]      wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic exmem_we, memwb_we, memwb_bubble;
    logic do_flush;

    assign do_flush = bus.flush_EX | pend_flush;

    // Priority: memory freeze > flush (current or pended) > load-use > normal.
    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            if (bus.mem_wait) begin
                memwb_we     = 1'b1;
                memwb_bubble = 1'b1;
            end else if (do_flush) begin
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                memwb_we    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (bus.stall_pipeline) begin
                idex_we     = 1'b1;
                idex_bubble = 1'b1;
                exmem_we    = 1'b1;
                memwb_we    = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pend_flush  <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (bus.mem_wait) begin
            state <= MWAIT;
            if (bus.flush_EX) pend_flush <= 1'b1;
            // First wait cycle leaves wait_cnt at 1; later cycles saturate.
            if (state == RUN)
                wait_cnt <= 16'd1;
            else if (wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt >= 16'(TIMEOUT - 1)) mem_timeout <= 1'b1;
        end else begin
            state      <= RUN;
            pend_flush <= 1'b0;
            wait_cnt   <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_we      = idex_we;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_we     = exmem_we;
    assign bus.memwb_we     = memwb_we;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;
    assign bus.mem_timeout  = mem_timeout;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pc_we;
        logic             ifid_we;
        logic             ifid_flush;
        logic             idex_we;
        logic             idex_bubble;
        logic             exmem_we;
        logic             memwb_we;
        logic             memwb_bubble;
        logic             mem_timeout;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
    } obs_t;

    logic clk;
    logic rst;
    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Model state: pending flush, consecutive wait cycles, timeout flag, counters.
    bit m_pend = 0;
    int m_run  = 0;
    bit m_tmo  = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    function automatic obs_t sample();
        obs_t a;
        a.pc_we        = bus.pc_we;
        a.ifid_we      = bus.ifid_we;
        a.ifid_flush   = bus.ifid_flush;
        a.idex_we      = bus.idex_we;
        a.idex_bubble  = bus.idex_bubble;
        a.exmem_we     = bus.exmem_we;
        a.memwb_we     = bus.memwb_we;
        a.memwb_bubble = bus.memwb_bubble;
        a.mem_timeout  = bus.mem_timeout;
        a.stall_cnt    = bus.stall_cnt;
        a.flush_cnt    = bus.flush_cnt;
        return a;
    endfunction

    // One cycle: apply inputs after the edge, predict this cycle's outputs, advance the model.
    task automatic drive(input bit r, input bit st, input bit fl, input bit mw, input bit mid = 0);
        obs_t e;
        obs_t a;
        bit   er;
        @(posedge clk);
        #1;
        bus.stall_pipeline = st;
        bus.flush_EX       = fl;
        bus.mem_wait       = mw;
        rst                = mid ? 1'b0 : r;
        if (mid) begin
            #1 rst = 1'b1;
            #1 a = sample();
            n_chk++;
            if (a !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL async_rst cyc%0d got %b required %b", cyc, a, obs_t'(0));
            end
        end
        er = r | mid;
        e  = '0;
        if (!er) begin
            e.mem_timeout = m_tmo;
            e.stall_cnt   = CNT_W'(m_scnt);
            e.flush_cnt   = CNT_W'(m_fcnt);
            if (mw) begin
                e.memwb_we = 1; e.memwb_bubble = 1;
            end else if (fl || m_pend) begin
                e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1; e.exmem_we = 1; e.memwb_we = 1;
                e.ifid_flush = 1; e.idex_bubble = 1;
            end else if (st) begin
                e.idex_we = 1; e.idex_bubble = 1; e.exmem_we = 1; e.memwb_we = 1;
            end else begin
                e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1; e.exmem_we = 1; e.memwb_we = 1;
            end
        end
        q.push_back(e);
        if (er) begin
            m_pend = 0; m_run = 0; m_tmo = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (!e.pc_we && m_scnt < CMAX) m_scnt++;
            if (e.ifid_flush && m_fcnt < CMAX) m_fcnt++;
            if (mw) begin
                m_pend = m_pend | fl;
                m_run++;
                if (m_run >= TIMEOUT) m_tmo = 1;
            end else begin
                m_pend = 0;
                m_run  = 0;
            end
        end
        cyc++;
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = sample();
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs got %b required %b (pc ifid ifflush idex idbub exm mwb mwbub tmo scnt fcnt)", a, e);
                end
            end
        end
    end

    initial begin : stim
        int burst;
        rst = 1'b1;
        bus.stall_pipeline = 0;
        bus.flush_EX       = 0;
        bus.mem_wait       = 0;
        repeat (2) drive(1, 0, 0, 0);
        repeat (10) drive(0, 0, 0, 0);
        // single load-use bubble
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        // flush beats load-use
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        // flush pended across a 3-cycle freeze
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0);
        // two flushes during one freeze give a single flush cycle
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 1);
        repeat (2) drive(0, 0, 0, 0);
        // timeout after the 4th wait cycle, sticky until reset
        drive(1, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        // counter saturation, then asynchronous reset mid-cycle
        repeat (10) drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0);
        // random traffic with bursty memory waits
        burst = 0;
        for (int i = 0; i < 600; i++) begin
            bit r, st, fl, mw, mid;
            r   = ($urandom_range(0, 59) == 0);
            mid = !r && ($urandom_range(0, 79) == 0);
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 9) < 2);
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 8);
            mw = (burst != 0);
            if (burst != 0) burst--;
            drive(r, st, fl, mw, mid);
        end
        @(posedge clk);
        #1;
        bus.stall_pipeline = 0;
        bus.flush_EX       = 0;
        bus.mem_wait       = 0;
        rst                = 0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left %0d required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
